// File: rtl/debounce_event_scheduler_pkg.sv
// Shared types and helpers for the button debounce / event scheduler slice.
// Channel state encoding, event kind values and a width helper.
package debounce_pkg;

   typedef enum logic [1:0] {
      IDLE_LO = 2'd0,
      WAIT_HI = 2'd1,
      IDLE_HI = 2'd2,
      WAIT_LO = 2'd3
   } ch_state_t;

   localparam logic EVT_RELEASE = 1'b0;
   localparam logic EVT_PRESS   = 1'b1;

   // Bits needed to hold values 0..v-1, never less than one.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int k = 0; k < 32; k++) begin
         if ((1 << r) < v) r = r + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/debounce_event_scheduler_if.sv
// Button event stream: valid/ready handshake plus channel id, kind and drop pulse.
// The scheduler is the master; the event consumer is the slave.
interface debounce_event_scheduler_if
   import debounce_pkg::*;
#(
   parameter int N_BTN = 4
);
   localparam int ID_W = clog2(N_BTN);

   logic            evt_valid;
   logic            evt_ready;
   logic [ID_W-1:0] evt_id;
   logic            evt_press;
   logic            evt_drop;

   modport master (
      output evt_valid,
      output evt_id,
      output evt_press,
      output evt_drop,
      input  evt_ready
   );

   modport slave (
      input  evt_valid,
      input  evt_id,
      input  evt_press,
      input  evt_drop,
      output evt_ready
   );
endinterface

// File: rtl/debounce_event_scheduler_channel.sv
// One button channel: input synchronizer, debounce FSM driven by the shared tick,
// registered debounced level and a one-cycle commit strobe with its kind.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int DEB_TICKS   = 20,
   parameter int SYNC_STAGES = 2
)
(
   input  logic clk,
   input  logic reset_n,
   input  logic noisy,
   input  logic tick,
   output logic level,
   output logic commit,
   output logic commit_kind
);

   localparam int CW = clog2(DEB_TICKS);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   s;
   ch_state_t              state_reg, state_next;
   logic [CW-1:0]          cnt_reg, cnt_next;
   logic                   level_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_reg  <= '0;
         state_reg <= IDLE_LO;
         cnt_reg   <= '0;
         level_reg <= 1'b0;
      end else begin
         sync_reg  <= {sync_reg[SYNC_STAGES-2:0], noisy};
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (commit) level_reg <= commit_kind;
      end
   end

   assign s     = sync_reg[SYNC_STAGES-1];
   assign level = level_reg;

   // The tick seen on entry to WAIT_* is ignored, so the first counted tick is partial.
   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      commit      = 1'b0;
      commit_kind = EVT_RELEASE;
      case (state_reg)
         IDLE_LO: begin
            if (s) begin
               state_next = WAIT_HI;
               cnt_next   = '0;
            end
         end
         WAIT_HI: begin
            if (!s) begin
               state_next = IDLE_LO;
            end else if (tick && cnt_reg == CW'(DEB_TICKS - 1)) begin
               state_next  = IDLE_HI;
               commit      = 1'b1;
               commit_kind = EVT_PRESS;
            end else if (tick) begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         IDLE_HI: begin
            if (!s) begin
               state_next = WAIT_LO;
               cnt_next   = '0;
            end
         end
         WAIT_LO: begin
            if (s) begin
               state_next = IDLE_HI;
            end else if (tick && cnt_reg == CW'(DEB_TICKS - 1)) begin
               state_next  = IDLE_LO;
               commit      = 1'b1;
               commit_kind = EVT_RELEASE;
            end else if (tick) begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         default: state_next = IDLE_LO;
      endcase
   end

endmodule

// File: rtl/debounce_event_scheduler.sv
// N_BTN debounced buttons on one shared prescaler; committed edges wait in
// per-channel slots and are delivered round-robin over a valid/ready stream.
module debounce_event_scheduler
   import debounce_pkg::*;
#(
   parameter int N_BTN       = 4,
   parameter int TICK_DIV    = 100000,
   parameter int DEB_TICKS   = 20,
   parameter int SYNC_STAGES = 2
)
(
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [N_BTN-1:0]             noisy,
   output logic [N_BTN-1:0]             debounced,
   output logic                         tick,
   debounce_event_scheduler_if.master   evt
);

   localparam int ID_W = clog2(N_BTN);
   localparam int PW   = clog2(TICK_DIV);

   logic [PW-1:0]    presc_reg;
   logic [N_BTN-1:0] commit, commit_kind;
   logic [N_BTN-1:0] slot_valid_reg, slot_valid_next;
   logic [N_BTN-1:0] slot_kind_reg, slot_kind_next;
   logic [N_BTN-1:0] grant, drop_hit;
   logic [ID_W-1:0]  rr_reg, winner;
   logic             any_pending, load;
   logic             valid_reg, press_reg, drop_reg;
   logic [ID_W-1:0]  id_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc_reg <= '0;
      end else if (presc_reg == PW'(TICK_DIV - 1)) begin
         presc_reg <= '0;
      end else begin
         presc_reg <= presc_reg + PW'(1);
      end
   end

   assign tick = (presc_reg == PW'(TICK_DIV - 1));

   generate
      for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
         debounce_channel #(
            .DEB_TICKS   (DEB_TICKS),
            .SYNC_STAGES (SYNC_STAGES)
         ) u_ch (
            .clk         (clk),
            .reset_n     (reset_n),
            .noisy       (noisy[gi]),
            .tick        (tick),
            .level       (debounced[gi]),
            .commit      (commit[gi]),
            .commit_kind (commit_kind[gi])
         );

         // A commit landing on the slot being granted this cycle refills it without a drop.
         assign grant[gi]           = load && (winner == ID_W'(gi));
         assign drop_hit[gi]        = commit[gi] && slot_valid_reg[gi] && !grant[gi];
         assign slot_valid_next[gi] = commit[gi] || (slot_valid_reg[gi] && !grant[gi]);
         assign slot_kind_next[gi]  = commit[gi] ? commit_kind[gi] : slot_kind_reg[gi];
      end
   endgenerate

   // First pending slot after the last winner, wrapping modulo N_BTN.
   always_comb begin
      int j;
      winner      = '0;
      any_pending = 1'b0;
      j           = 0;
      for (int k = 1; k <= N_BTN; k++) begin
         j = int'(rr_reg) + k;
         if (j >= N_BTN) j = j - N_BTN;
         if (!any_pending && slot_valid_reg[j]) begin
            winner      = ID_W'(j);
            any_pending = 1'b1;
         end
      end
   end

   assign load = (!valid_reg || evt.evt_ready) && any_pending;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         slot_valid_reg <= '0;
         slot_kind_reg  <= '0;
         rr_reg         <= ID_W'(N_BTN - 1);
         valid_reg      <= 1'b0;
         id_reg         <= '0;
         press_reg      <= 1'b0;
         drop_reg       <= 1'b0;
      end else begin
         slot_valid_reg <= slot_valid_next;
         slot_kind_reg  <= slot_kind_next;
         drop_reg       <= |drop_hit;
         if (load) begin
            valid_reg <= 1'b1;
            id_reg    <= winner;
            press_reg <= slot_kind_reg[winner];
            rr_reg    <= winner;
         end else if (evt.evt_ready) begin
            valid_reg <= 1'b0;
         end
      end
   end

   assign evt.evt_valid = valid_reg;
   assign evt.evt_id    = id_reg;
   assign evt.evt_press = press_reg;
   assign evt.evt_drop  = drop_reg;

endmodule

// File: tb/tb_debounce_event_scheduler.sv
// Directed bench for debounce_event_scheduler with a cycle-level reference model
// of debounce timing and round-robin delivery, plus hand-computed expectations.
module tb_debounce_event_scheduler;
   import debounce_pkg::*;

   localparam int N   = 4;
   localparam int DIV = 4;
   localparam int DEB = 3;
   localparam int SYN = 2;

   logic         clk;
   logic         reset_n;
   logic [N-1:0] noisy;
   logic         evt_ready;
   logic [N-1:0] debounced;
   logic         tick;

   debounce_event_scheduler_if #(.N_BTN(N)) evt_bus ();
   assign evt_bus.evt_ready = evt_ready;

   debounce_event_scheduler #(
      .N_BTN(N), .TICK_DIV(DIV), .DEB_TICKS(DEB), .SYNC_STAGES(SYN)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .noisy     (noisy),
      .debounced (debounced),
      .tick      (tick),
      .evt       (evt_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errs   = 0;
   int checks = 0;

   // ---------------- reference model ----------------
   int cyc;
   bit hist   [N][SYN];
   bit m_lvl  [N];
   bit in_wait[N];
   int nticks [N];
   bit slot_v [N];
   bit slot_k [N];
   bit m_valid, m_press, m_drop, m_tick;
   int m_id, m_rr;
   bit cm[N];
   bit tick_now, take, drop_any;
   int win;

   task automatic model_reset();
      cyc = 0;
      for (int i = 0; i < N; i++) begin
         for (int k = 0; k < SYN; k++) hist[i][k] = 1'b0;
         m_lvl[i] = 1'b0; in_wait[i] = 1'b0; nticks[i] = 0;
         slot_v[i] = 1'b0; slot_k[i] = 1'b0;
      end
      m_valid = 0; m_press = 0; m_drop = 0; m_tick = 0; m_id = 0; m_rr = N - 1;
   endtask

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         model_reset();
      end else begin
         tick_now = (cyc % DIV) == DIV - 1;
         // debounce: a differing level must persist across DEB ticks seen after it is noticed
         for (int i = 0; i < N; i++) begin
            cm[i] = 1'b0;
            if (!in_wait[i]) begin
               if (hist[i][SYN-1] != m_lvl[i]) begin
                  in_wait[i] = 1'b1;
                  nticks[i]  = 0;
               end
            end else if (hist[i][SYN-1] == m_lvl[i]) begin
               in_wait[i] = 1'b0;
            end else if (tick_now) begin
               nticks[i] = nticks[i] + 1;
               if (nticks[i] == DEB) begin
                  cm[i]      = 1'b1;
                  m_lvl[i]   = hist[i][SYN-1];
                  in_wait[i] = 1'b0;
               end
            end
         end
         for (int i = 0; i < N; i++) begin
            for (int k = SYN - 1; k > 0; k--) hist[i][k] = hist[i][k-1];
            hist[i][0] = noisy[i];
         end
         take = !m_valid || evt_ready;
         win  = -1;
         if (take) begin
            for (int k = 1; k <= N; k++) begin
               if (win < 0 && slot_v[(m_rr + k) % N]) win = (m_rr + k) % N;
            end
         end
         if (win >= 0) begin
            m_valid     = 1'b1;
            m_id        = win;
            m_press     = slot_k[win];
            slot_v[win] = 1'b0;
            m_rr        = win;
         end else if (take) begin
            m_valid = 1'b0;
         end
         drop_any = 1'b0;
         for (int i = 0; i < N; i++) begin
            if (cm[i]) begin
               if (slot_v[i]) drop_any = 1'b1;
               slot_v[i] = 1'b1;
               slot_k[i] = m_lvl[i];
            end
         end
         m_drop = drop_any;
         cyc    = cyc + 1;
         m_tick = (cyc % DIV) == DIV - 1;
      end
   end

   // ---------------- per-cycle compare and transfer log ----------------
   int tb_cyc = 0;
   int xid[$];
   int xpress[$];
   int xcyc[$];
   int drop_cnt = 0;

   always @(posedge clk) tb_cyc <= tb_cyc + 1;

   always @(negedge clk) begin
      logic [N-1:0] m_deb;
      if (reset_n) begin
         for (int i = 0; i < N; i++) m_deb[i] = m_lvl[i];
         checks = checks + 1;
         if (debounced !== m_deb || evt_bus.evt_valid !== m_valid || tick !== m_tick ||
             evt_bus.evt_drop !== m_drop ||
             (m_valid && (int'(evt_bus.evt_id) != m_id || evt_bus.evt_press !== m_press))) begin
            errs = errs + 1;
            $display("FAIL cycle_model t=%0t: deb %b/%b valid %b/%b id %0d/%0d press %b/%b drop %b/%b tick %b/%b (got/want)",
                     $time, debounced, m_deb, evt_bus.evt_valid, m_valid, evt_bus.evt_id, m_id,
                     evt_bus.evt_press, m_press, evt_bus.evt_drop, m_drop, tick, m_tick);
         end
         if (evt_bus.evt_valid && evt_ready) begin
            xid.push_back(int'(evt_bus.evt_id));
            xpress.push_back(int'(evt_bus.evt_press));
            xcyc.push_back(tb_cyc);
         end
         if (evt_bus.evt_drop) drop_cnt = drop_cnt + 1;
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act != exp) begin
         errs = errs + 1;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_deb(input int ch, input bit val, output int n);
      n = 0;
      while (debounced[ch] !== val && n < 40) begin
         step(1);
         n = n + 1;
      end
      if (debounced[ch] !== val) begin
         errs   = errs + 1;
         checks = checks + 1;
         $display("FAIL wait_deb ch%0d: level %b not reached within 40 cycles", ch, val);
      end
   endtask

   task automatic clear_log();
      xid.delete(); xpress.delete(); xcyc.delete();
      drop_cnt = 0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      noisy   = '0;
      step(2);
      reset_n = 1'b1;
      clear_log();
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      int pos;
      reset_n   = 1'b0;
      noisy     = '0;
      evt_ready = 1'b0;
      #1;
      chk("reset_debounced", int'(debounced), 0);
      chk("reset_valid", int'(evt_bus.evt_valid), 0);
      do_reset();

      // 1: single press on ch1
      evt_ready = 1'b1;
      noisy[1]  = 1'b1;
      wait_deb(1, 1'b1, n);
      $display("t1: debounced[1] rose after %0d cycles", n);
      chk("t1_latency_12to15", int'(n >= 12 && n <= 15), 1);
      step(3);
      chk("t1_event_count", xid.size(), 1);
      if (xid.size() >= 1) begin
         chk("t1_id", xid[0], 1);
         chk("t1_press", xpress[0], 1);
      end

      // 2: short glitches are rejected
      clear_log();
      noisy[2] = 1'b1; step(5); noisy[2] = 1'b0; step(30);
      chk("t2_hi_glitch_deb", int'(debounced[2]), 0);
      chk("t2_hi_glitch_events", xid.size(), 0);
      noisy[2] = 1'b1;
      wait_deb(2, 1'b1, n);
      step(3);
      clear_log();
      noisy[2] = 1'b0; step(5); noisy[2] = 1'b1; step(30);
      chk("t2_lo_glitch_deb", int'(debounced[2]), 1);
      chk("t2_lo_glitch_events", xid.size(), 0);

      // 3: simultaneous presses on ch0 and ch2 after reset
      do_reset();
      evt_ready = 1'b1;
      noisy     = 4'b0101;
      wait_deb(0, 1'b1, n);
      step(3);
      chk("t3_event_count", xid.size(), 2);
      if (xid.size() >= 2) begin
         chk("t3_first_id", xid[0], 0);
         chk("t3_second_id", xid[1], 2);
         chk("t3_second_press", xpress[1], 1);
         chk("t3_back_to_back", xcyc[1] - xcyc[0], 1);
      end

      // 4: stall, ch3 press then release overwrites its slot
      evt_ready = 1'b0;
      clear_log();
      noisy[1] = 1'b1; wait_deb(1, 1'b1, n);
      noisy[3] = 1'b1; wait_deb(3, 1'b1, n);
      noisy[3] = 1'b0; wait_deb(3, 1'b0, n);
      step(3);
      chk("t4_stall_valid", int'(evt_bus.evt_valid), 1);
      chk("t4_stall_id", int'(evt_bus.evt_id), 1);
      chk("t4_stall_press", int'(evt_bus.evt_press), 1);
      chk("t4_drop_pulses", drop_cnt, 1);
      evt_ready = 1'b1;
      step(4);
      chk("t4_event_count", xid.size(), 2);
      if (xid.size() >= 2) begin
         chk("t4_ch3_id", xid[1], 3);
         chk("t4_ch3_release", xpress[1], 0);
      end

      // 5: reset while busy discards everything
      do_reset();
      evt_ready = 1'b0;
      noisy[0] = 1'b1; wait_deb(0, 1'b1, n);
      noisy[2] = 1'b1; wait_deb(2, 1'b1, n);
      noisy[1] = 1'b1; step(4);
      chk("t5_pre_valid", int'(evt_bus.evt_valid), 1);
      reset_n = 1'b0;
      #1;
      chk("t5_rst_deb", int'(debounced), 0);
      chk("t5_rst_valid", int'(evt_bus.evt_valid), 0);
      chk("t5_rst_id", int'(evt_bus.evt_id), 0);
      chk("t5_rst_press", int'(evt_bus.evt_press), 0);
      chk("t5_rst_drop_tick", int'({evt_bus.evt_drop, tick}), 0);
      noisy = '0;
      step(2);
      reset_n = 1'b1;
      clear_log();
      evt_ready = 1'b1;
      step(40);
      chk("t5_no_stale_events", xid.size(), 0);

      // 6: busy ch0 must not starve a pending ch1
      do_reset();
      evt_ready = 1'b0;
      noisy[0] = 1'b1; wait_deb(0, 1'b1, n);
      noisy[1] = 1'b1; wait_deb(1, 1'b1, n);
      noisy[0] = 1'b0; wait_deb(0, 1'b0, n);
      clear_log();
      evt_ready = 1'b1;
      for (int r = 0; r < 4; r++) begin
         noisy[0] = ~noisy[0];
         wait_deb(0, noisy[0], n);
      end
      step(3);
      pos = -1;
      for (int k = xid.size() - 1; k >= 0; k--) if (xid[k] == 1) pos = k;
      $display("t6: %0d events, ch1 served at grant %0d", xid.size(), pos);
      chk("t6_ch1_within_2", int'(pos >= 0 && pos <= 1), 1);
      if (xid.size() >= 3) begin
         chk("t6_first_id0", xid[0], 0);
         chk("t6_third_ch0_release", xpress[2], 0);
      end
      chk("t6_event_count", xid.size(), 7);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
